metastable_harvester: RTL and testbench
=======================================

# metastable_harvester

Controller that samples the free-running `metastable` output of the iCE40 metastable oscillator and sequences it into whole random words. It synchronizes the raw bit, samples it at a fixed divided rate and removes bias with a von Neumann extractor. It packs debiased bits into `WIDTH`-bit words and hands each word out over a valid/ready handshake. It sits between the oscillator and any consumer of entropy, such as seed registers or key generators.

## Interface
Parameters:
- `WIDTH`, 8: bits per output word (≥2).
- `SAMPLE_DIV`, 4: clocks between raw samples (≥1).
- `REPEAT_LIMIT`, 32: run length of identical raw samples that trips the health fault (≥2; used only with the health feature).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `metastable`  in  1  asynchronous raw bit from the oscillator.
- `enable`  in  1  sampling permitted.
- `out_data`  out  WIDTH  random word.
- `out_valid`  out  1  `out_data` holds a complete word.
- `out_ready`  in  1  consumer accepts the word.
- `fault`  out  1  health test tripped; sticky until `rst`.

## Operation
- **Synchronizer:** `metastable` passes through a 2-flop synchronizer; only the second flop is used downstream.
- **Sample tick:** counter runs 0..`SAMPLE_DIV`-1. A tick occurs when the count equals `SAMPLE_DIV`-1, then the counter wraps to 0.
  - The counter advances only in state FILL with `enable`=1.
  - With `enable`=0 the counter, pair stage and partial word all hold.
- **Pair stage:**
  - First tick of a pair: the sample is stored and `half` is set.
  - Second tick: `half` clears and the two samples are compared.
  - 10 emits 1. 01 emits 0. 00 and 11 are discarded.
- **Packing:** an emitted bit shifts in at the LSB (word <= {word[WIDTH-2:0], bit}), so the first bit ends up in the MSB. A bit counter counts 0..`WIDTH`.
- **States:**
  - FILL: collecting bits. When the `WIDTH`th bit is emitted, copy the word to `out_data` and go to HOLD.
  - HOLD: `out_valid`=1 and `out_data` is stable. Sampling stops and the sample counter holds. If `out_valid`&&`out_ready`, go to FILL with the bit counter, word and `half` cleared.
  - FAULT (health build only): `out_valid`=0 and `fault`=1. Leaves only on `rst`.
- **Reset values:** `out_data`=0, `out_valid`=0, `fault`=0, state FILL, all counters and `half` cleared.
- **Reset mid-operation:** `rst` discards any partial word and any held word, and clears `fault`.

## Timing
- Synchronizer latency is 2 clocks from `metastable` to the sample point.
- `out_valid` rises the cycle after the clock edge that registers the pair completing the word.
- Transfer happens on each edge with `out_valid`&&`out_ready`. `out_valid` is low in the following cycle.
- The minimum gap between words is `2*WIDTH*SAMPLE_DIV` clocks plus 1.
- `out_ready` high while `out_valid`=0 has no effect.
- `out_data` is unchanged from the rise of `out_valid` until the transfer.
- `enable` low on a tick cycle suppresses that tick.
- `enable` low in HOLD does not affect the handshake.

## Configuration
- Macro: `METASTABLE_HARVESTER_HEALTH_EN`.
- Defined: a repetition-count test runs on every raw sample tick, including ticks later discarded by the pair stage.
  - Run length = 1 on a sample that differs from the previous one, otherwise +1, saturating.
  - When the run length reaches `REPEAT_LIMIT`, go to FAULT on that edge. `fault`=1 and `out_valid`=0 from the next cycle. The partial word is discarded.
  - Trips only in FILL, since no ticks occur in HOLD.
- Undefined: there is no run counter and no FAULT state, and `fault` is tied to 0.

## Test plan
All scenarios use `WIDTH`=8, `SAMPLE_DIV`=1, `REPEAT_LIMIT`=32, and drive `metastable` from a bench pattern held stable per tick.
- **Reset:** `rst`=1 for 2 cycles with random `metastable` → `out_data`=0x00, `out_valid`=0, `fault`=0.
- **Packing:** pairs 10,01,10,10,01,01,10,01 with `enable`=1 and `out_ready`=0 → `out_valid`=1 with `out_data`=0xB2, appearing 1 cycle after the 16th sample is registered.
- **Discards:** the same stream with a 00 and a 11 pair inserted after pair 3 → still 0xB2, `out_valid` delayed by 4 clocks.
- **Backpressure and enable:**
  - Hold `out_ready`=0 for 20 cycles after `out_valid` → `out_data` stays 0xB2 and no ticks occur.
  - Then `out_ready`=1 for 1 cycle → exactly one transfer, `out_valid`=0 on the next cycle.
  - `enable`=0 for 10 cycles after 3 pairs, then resume → the word is identical to the uninterrupted case.
- **Health, macro defined:** constant `metastable`=0 for 32 ticks → `fault`=1 and `out_valid`=0, persisting through 100 further cycles of alternating input; `rst` clears `fault`.
- **Health, macro undefined:** constant 0 for 100 ticks → `fault`=0 and no word is produced.

Source files
------------

// File: rtl/metastable_harvester.sv
// Entropy harvester for the iCE40 metastable oscillator: synchronize, sample, von Neumann debias, pack words.
// Optional repetition-count health test is compiled in with METASTABLE_HARVESTER_HEALTH_EN.
module metastable_harvester #(
  parameter int WIDTH        = 8,
  parameter int SAMPLE_DIV   = 4,
  parameter int REPEAT_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             metastable,
  input  logic             enable,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

`ifdef METASTABLE_HARVESTER_HEALTH_EN
  typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             tick, emit, emit_bit;

`ifdef METASTABLE_HARVESTER_HEALTH_EN
  localparam int RUN_W = $clog2(REPEAT_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REPEAT_LIMIT);
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             fault_q, fault_d;
`endif

  always_comb begin
    sync1_d     = metastable;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    first_d     = first_q;
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tick        = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b0;
`ifdef METASTABLE_HARVESTER_HEALTH_EN
    run_d       = run_q;
    prev_d      = prev_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      FILL: begin
        if (enable) begin
          tick  = (cnt_q == CNT_MAX);
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (!half_q) begin
              first_d = sync2_q;
              half_d  = 1'b1;
            end else begin
              half_d = 1'b0;
              // Unequal pair 10 yields 1 and 01 yields 0, i.e. the first sample.
              if (first_q != sync2_q) begin
                emit     = 1'b1;
                emit_bit = first_q;
              end
            end
          end
          if (emit) begin
            word_d    = {word_q[WIDTH-2:0], emit_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              out_data_d  = word_d;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end
          end
`ifdef METASTABLE_HARVESTER_HEALTH_EN
          // Every raw tick counts toward the run, including discarded pairs.
          if (tick) begin
            prev_d = sync2_q;
            if (sync2_q != prev_q)    run_d = RUN_W'(1);
            else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
            if (run_d == RUN_MAX) begin
              state_d     = FAULT;
              fault_d     = 1'b1;
              out_valid_d = 1'b0;
              word_d      = '0;
              bit_cnt_d   = '0;
              half_d      = 1'b0;
            end
          end
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = FILL;
          out_valid_d = 1'b0;
          bit_cnt_d   = '0;
          word_d      = '0;
          half_d      = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      first_q     <= 1'b0;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef METASTABLE_HARVESTER_HEALTH_EN
      run_q       <= '0;
      prev_q      <= 1'b0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      first_q     <= first_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef METASTABLE_HARVESTER_HEALTH_EN
      run_q       <= run_d;
      prev_q      <= prev_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef METASTABLE_HARVESTER_HEALTH_EN
  assign fault = fault_q;
`else
  logic unused_repeat_limit;
  assign unused_repeat_limit = ^REPEAT_LIMIT;
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_metastable_harvester.sv
// Directed bench for metastable_harvester (WIDTH=8, SAMPLE_DIV=1, REPEAT_LIMIT=32).
// Health checks follow METASTABLE_HARVESTER_HEALTH_EN the same way the design does.
module tb_metastable_harvester;

  logic       clk = 1'b0;
  logic       rst;
  logic       metastable;
  logic       enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       fault;

  int total = 0;
  int bad   = 0;

  metastable_harvester #(
    .WIDTH        (8),
    .SAMPLE_DIV   (1),
    .REPEAT_LIMIT (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .metastable (metastable),
    .enable     (enable),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Streams n bits (MSB first) so each reaches the synchronizer output exactly when its tick
  // is enabled; pause_len enable-low cycles are inserted once pause_at bits have been consumed.
  task automatic applyStimulus(input logic [31:0] bits, input int n, input int pause_at,
                               input int pause_len, input string tag);
    logic m_arr [64];
    logic e_arr [64];
    int   tot;
    int   consumed;
    int   paused;
    int   idx;
    tot      = n + pause_len + 2;
    consumed = 0;
    paused   = 0;
    for (int i = 0; i < 64; i++) begin
      m_arr[i] = 1'b0;
      e_arr[i] = 1'b0;
    end
    for (int i = 2; i < tot; i++) begin
      idx = (consumed < n) ? consumed : n - 1;
      m_arr[i-2] = bits[n-1-idx];
      if (pause_len > 0 && consumed == pause_at && paused < pause_len) begin
        e_arr[i] = 1'b0;
        paused++;
      end else begin
        e_arr[i] = 1'b1;
        consumed++;
      end
    end
    for (int i = 0; i < tot; i++) begin
      @(posedge clk); #1;
      metastable = m_arr[i];
      enable     = e_arr[i];
      if (i == tot - 1) checkOutput({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    enable = 1'b0;
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_data"}, {24'b0, out_data}, 32'hB2);
  endtask

  task automatic transferWord(input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    enable    = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_xfer_valid_low"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_xfer_stays_low"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    out_ready  = 1'b0;
    metastable = 1'($urandom);

    // Reset with random raw input.
    repeat (2) begin
      @(posedge clk); #1;
      metastable = 1'($urandom);
    end
    checkOutput("reset_data", {24'b0, out_data}, 32'h00);
    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_fault", {31'b0, fault}, 32'd0);
    rst = 1'b0;

    // Pairs 10,01,10,10,01,01,10,01 -> 0xB2.
    applyStimulus(32'h9A59, 16, 0, 0, "pack");

    // Backpressure: the word must hold while raw input toggles with enable high.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      metastable = i[0];
      enable     = 1'b1;
      checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_data", {24'b0, out_data}, 32'hB2);
    end
    transferWord("pack");

    // Same stream with a 00 and an 11 pair inserted after pair 3.
    applyStimulus(32'h98E59, 20, 0, 0, "discard");
    transferWord("discard");

    // Enable dropped for 10 cycles after 3 pairs.
    applyStimulus(32'h9A59, 16, 6, 10, "pause");

    // Reset while a word is held.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_data", {24'b0, out_data}, 32'h00);

    // Odd number of ticks leaves a half pair; reset must clear it.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      metastable = (i % 3 == 0);
      enable     = 1'b1;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(32'h9A59, 16, 0, 0, "after_partial");

    // Health: constant zero input from a clean reset.
    @(posedge clk); #1;
    rst        = 1'b1;
    metastable = 1'b0;
    enable     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
`ifdef METASTABLE_HARVESTER_HEALTH_EN
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == 31) checkOutput("health_pre_trip", {31'b0, fault}, 32'd0);
    end
    checkOutput("health_fault", {31'b0, fault}, 32'd1);
    checkOutput("health_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      metastable = i[0];
      if (i % 25 == 24) begin
        checkOutput("health_sticky_fault", {31'b0, fault}, 32'd1);
        checkOutput("health_sticky_valid", {31'b0, out_valid}, 32'd0);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("health_rst_fault", {31'b0, fault}, 32'd0);
    checkOutput("health_rst_valid", {31'b0, out_valid}, 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k % 25 == 0 || k == 32) checkOutput("nohealth_fault", {31'b0, fault}, 32'd0);
    end
    checkOutput("nohealth_valid", {31'b0, out_valid}, 32'd0);
`endif
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
